interp_coord_scheduler: RTL and testbench
=========================================

Name: interp_coord_scheduler

Overview:
Sequences coordinate generation for the bilinear interpolation datapath. On a start pulse it scans a frame of (width_m1+1) x (height_m1+1) base pixels in raster order. For each base pixel it emits the four neighbour coordinates (x,y), (x+1,y), (x,y+1), (x+1,y+1) over a valid/ready stream to the pixel fetch stage. It replaces ad-hoc "coord + 1" sequencing: edge clamping, back-pressure and frame completion are handled in one place.

Parameters:
COORD_W, 8, width of X and Y coordinates and of the dimension inputs

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request to begin a frame scan; accepted only in IDLE
width_m1  input  COORD_W  frame width minus 1; sampled on accepted start
height_m1  input  COORD_W  frame height minus 1; sampled on accepted start
out_valid  output  1  coordinate beat available
out_ready  input  1  downstream accepts beat; transfer = out_valid & out_ready
out_x  output  COORD_W  neighbour X coordinate
out_y  output  COORD_W  neighbour Y coordinate
out_corner  output  2  neighbour index: 0=(x,y), 1=(x+1,y), 2=(x,y+1), 3=(x+1,y+1)
out_last  output  1  final beat of frame (corner 3 of last base pixel)
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after final transfer

Behaviour:
- Reset: state IDLE. out_valid, out_x, out_y, out_corner, out_last, busy and done are all 0. Latched dimensions, base counters and corner counter are 0.
- Reset mid-frame: abort immediately to IDLE. No done pulse. The partial frame is discarded.
- FSM states: IDLE, EMIT, DONE.
- IDLE, start=1: latch width_m1/height_m1, set base bx=0, by=0 and corner=0, go to EMIT. busy=1 from the next cycle.
- Latency: the first beat (0,0,c0) has out_valid=1 on the cycle after start is accepted.
- start while busy is ignored; latched dimensions are unchanged.
- EMIT: out_valid=1. All outputs are registered and must stay stable while out_valid & !out_ready.
- Each transfer advances corner 0->1->2->3. Throughput is one beat per cycle while out_ready=1.
- On a corner-3 transfer:
  - if bx<width_m1: bx++;
  - else: bx=0, by++;
  - if bx==width_m1 and by==height_m1: go to DONE.
- Increment/clamp rule: x+1 = min(bx+1, width_m1) and y+1 = min(by+1, height_m1), i.e. edge replication. Computed at COORD_W+1 bits so 255+1 never wraps to 0.
- out_last=1 only with corner 3 of base (width_m1, height_m1).
- DONE: out_valid=0, done=1 for exactly one cycle, busy=0, then IDLE. A start arriving in DONE is ignored.
- Zero-size frame (width_m1=0, height_m1=0): exactly 4 beats, all (0,0), corners 0..3, last on the 4th.
- Total beats per frame = 4*(width_m1+1)*(height_m1+1).

Decomposition:
- Shared include/package holds:
  - FSM state encodings (IDLE=2'd0, EMIT=2'd1, DONE=2'd2);
  - corner codes CORNER_00/10/01/11;
  - COORD_W default.
- One sub-module, coord_inc_clamp: combinational, inputs base and limit, output min(base+1, limit). Instantiated twice, for X and Y.
- Counters and FSM live in the top block.

Test Plan:
1. width_m1=1, height_m1=1, out_ready=1, start pulse at cycle 0 -> 16 beats, cycles 1..16. Beat 5 is (1,0,c0); beat 6 is (1,0,c1) with x clamped to 1. Beat 16 is (1,1,c3) with out_last=1. done=1 at cycle 17, busy=0 at cycle 17.
2. Same frame, out_ready toggled 1,0,0,1,... -> no beat lost or duplicated. out_x/out_y/out_corner hold during stalls. Still 16 transfers, done one cycle after the last transfer.
3. width_m1=0, height_m1=0 -> four (0,0) beats, corners 0..3, out_last on the 4th.
4. Start pulse with width_m1=3, a second start with width_m1=7 during beat 2 -> scan uses width 4 (16 bases, 64 beats). Second start ignored.
5. rst asserted during beat 10 of a 2x2 frame -> next cycle out_valid=0, busy=0, no done pulse. A new start then begins at (0,0,c0).
6. width_m1=255, height_m1=0 -> base (255,0) corner1 gives out_x=255, no wrap to 0. Total 1024 beats, out_last only on the final one.

Source files
------------

// File: rtl/interp_coord_scheduler_pkg.sv
// Shared types and constants for the bilinear coordinate scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package interp_coord_scheduler_pkg;

    localparam int COORD_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Neighbour index: bit 0 selects x+1, bit 1 selects y+1
    localparam logic [1:0] CORNER_00 = 2'd0;
    localparam logic [1:0] CORNER_10 = 2'd1;
    localparam logic [1:0] CORNER_01 = 2'd2;
    localparam logic [1:0] CORNER_11 = 2'd3;

endpackage

// File: rtl/interp_coord_scheduler_coord_inc_clamp.sv
// Edge-replicating increment: inc = min(base + 1, limit).
// Latency: combinational.
// Backpressure: not applicable.
module coord_inc_clamp #(
    parameter int W = 8
) (
    input  logic [W-1:0] base,
    input  logic [W-1:0] limit,
    output logic [W-1:0] inc
);

    // One extra bit so base = all-ones does not wrap to zero before the compare
    logic [W:0] sum;

    // Clamp the widened sum against the limit
    always_comb begin
        sum = {1'b0, base} + {{W{1'b0}}, 1'b1};
        inc = (sum > {1'b0, limit}) ? limit : sum[W-1:0];
    end

endmodule

// File: rtl/interp_coord_scheduler.sv
// Raster-scans a frame and emits the four bilinear neighbour coordinates per base pixel.
// Latency: first beat valid the cycle after an accepted start; one beat per cycle when ready.
// Backpressure: all outputs registered and held while out_valid & !out_ready.
module interp_coord_scheduler
    import interp_coord_scheduler_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] width_m1,
    input  logic [COORD_W-1:0] height_m1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [1:0]         out_corner,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    state_t             state;
    logic [COORD_W-1:0] w_lat;
    logic [COORD_W-1:0] h_lat;
    logic [COORD_W-1:0] bx;
    logic [COORD_W-1:0] by;
    logic [1:0]         corner;

    logic [COORD_W-1:0] nxt_w;
    logic [COORD_W-1:0] nxt_h;
    logic [COORD_W-1:0] nxt_bx;
    logic [COORD_W-1:0] nxt_by;
    logic [1:0]         nxt_corner;
    logic [COORD_W-1:0] x_inc;
    logic [COORD_W-1:0] y_inc;
    logic               launch;
    logic               xfer;
    logic               frame_end;

    assign launch    = (state == ST_IDLE) && start;
    assign xfer      = (state == ST_EMIT) && out_ready;
    assign frame_end = xfer && (corner == CORNER_11) && (bx == w_lat) && (by == h_lat);

    // Next scan position: load on launch, step corner per transfer, raster step after corner 3
    always_comb begin
        nxt_w      = w_lat;
        nxt_h      = h_lat;
        nxt_bx     = bx;
        nxt_by     = by;
        nxt_corner = corner;
        if (launch) begin
            nxt_w      = width_m1;
            nxt_h      = height_m1;
            nxt_bx     = '0;
            nxt_by     = '0;
            nxt_corner = CORNER_00;
        end else if (xfer) begin
            nxt_corner = corner + 2'd1;
            if (corner == CORNER_11) begin
                if (bx < w_lat) begin
                    nxt_bx = bx + ONE;
                end else begin
                    nxt_bx = '0;
                    nxt_by = by + ONE;
                end
            end
        end
    end

    // Neighbour coordinates are derived from the next position so outputs can be registered
    coord_inc_clamp #(.W(COORD_W)) u_x_inc (
        .base  (nxt_bx),
        .limit (nxt_w),
        .inc   (x_inc)
    );

    coord_inc_clamp #(.W(COORD_W)) u_y_inc (
        .base  (nxt_by),
        .limit (nxt_h),
        .inc   (y_inc)
    );

    // Scan FSM with registered stream outputs and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            w_lat      <= '0;
            h_lat      <= '0;
            bx         <= '0;
            by         <= '0;
            corner     <= CORNER_00;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_corner <= CORNER_00;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            w_lat  <= nxt_w;
            h_lat  <= nxt_h;
            bx     <= nxt_bx;
            by     <= nxt_by;
            corner <= nxt_corner;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_EMIT;
                        busy       <= 1'b1;
                        out_valid  <= 1'b1;
                        out_x      <= '0;
                        out_y      <= '0;
                        out_corner <= CORNER_00;
                        out_last   <= (nxt_w == '0) && (nxt_h == '0) && (nxt_corner == CORNER_11);
                    end
                end
                ST_EMIT: begin
                    if (frame_end) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (xfer) begin
                        out_x      <= ((nxt_corner == CORNER_10) || (nxt_corner == CORNER_11)) ? x_inc : nxt_bx;
                        out_y      <= ((nxt_corner == CORNER_01) || (nxt_corner == CORNER_11)) ? y_inc : nxt_by;
                        out_corner <= nxt_corner;
                        out_last   <= (nxt_corner == CORNER_11) && (nxt_bx == nxt_w) && (nxt_by == nxt_h);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interp_coord_scheduler.sv
// Self-checking bench: frames scored against a nested-loop model of the neighbour sequence.
// Latency: n/a.
// Backpressure: out_ready driven always-on, patterned or random.
module tb_interp_coord_scheduler;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] width_m1;
    logic [7:0] height_m1;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_x;
    logic [7:0] out_y;
    logic [1:0] out_corner;
    logic       out_last;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [18:0] exp_q[$];

    interp_coord_scheduler #(.COORD_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .width_m1   (width_m1),
        .height_m1  (height_m1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_corner (out_corner),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic run_frame(input logic [7:0] w, input logic [7:0] h, input int mode,
                             input int restart_beat, input int abort_beat);
        int n;
        int idx;
        int cyc;
        int limit;
        logic held;
        logic rdy;
        logic [18:0] held_beat;
        logic [18:0] cur;

        exp_q.delete();
        for (int yy = 0; yy <= int'(h); yy++) begin
            for (int xx = 0; xx <= int'(w); xx++) begin
                for (int c = 0; c < 4; c++) begin
                    int ex;
                    int ey;
                    ex = (c % 2 == 1) ? ((xx + 1 > int'(w)) ? int'(w) : xx + 1) : xx;
                    ey = (c >= 2) ? ((yy + 1 > int'(h)) ? int'(h) : yy + 1) : yy;
                    exp_q.push_back({8'(ex), 8'(ey), 2'(c),
                                     (c == 3 && xx == int'(w) && yy == int'(h))});
                end
            end
        end
        n     = exp_q.size();
        limit = n * 20 + 50;

        @(negedge clk);
        width_m1  = w;
        height_m1 = h;
        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        width_m1  = 8'($urandom);
        height_m1 = 8'($urandom);

        idx  = 0;
        cyc  = 0;
        held = 1'b0;
        held_beat = '0;
        while (idx < n && cyc < limit) begin
            chk("valid_in_frame", 32'(out_valid), 32'd1);
            chk("busy_in_frame", 32'(busy), 32'd1);
            chk("done_in_frame", 32'(done), 32'd0);
            cur = {out_x, out_y, out_corner, out_last};
            if (held) chk("stall_hold", 32'(cur), 32'(held_beat));

            if (idx == abort_beat) begin
                rst       = 1'b1;
                out_ready = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_valid", 32'(out_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                @(negedge clk);
                chk("abort_no_done", 32'(done), 32'd0);
                chk("abort_idle_valid", 32'(out_valid), 32'd0);
                return;
            end

            if (idx == restart_beat) begin
                start    = 1'b1;
                width_m1 = 8'd7;
            end else begin
                start = 1'b0;
            end

            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            out_ready = rdy;

            if (rdy) begin
                chk("beat", 32'(cur), 32'(exp_q[idx]));
                idx++;
                held = 1'b0;
            end else begin
                held      = 1'b1;
                held_beat = cur;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        chk("beats_transferred", 32'(idx), 32'(n));
        if (mode == 0) chk("back_to_back_cycles", 32'(cyc), 32'(n));

        // One cycle after the final transfer
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(out_valid), 32'd0);
        out_ready = 1'(($urandom_range(0, 1)));
        start     = 1'b1;
        width_m1  = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("start_in_done_ignored", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        width_m1  = '0;
        height_m1 = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_xy", 32'({out_x, out_y}), 32'd0);
        chk("rst_corner_last", 32'({out_corner, out_last}), 32'd0);
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_valid", 32'(out_valid), 32'd0);

        // 2x2 frame, always ready
        run_frame(8'd1, 8'd1, 0, -1, -1);
        // 2x2 frame, ready pattern with stalls
        run_frame(8'd1, 8'd1, 1, -1, -1);
        // single pixel frame
        run_frame(8'd0, 8'd0, 2, -1, -1);
        // 4x4 frame with an ignored second start during beat 2
        run_frame(8'd3, 8'd3, 0, 1, -1);
        // reset during beat 10, then a clean restart
        run_frame(8'd1, 8'd1, 0, -1, 9);
        run_frame(8'd1, 8'd1, 0, -1, -1);
        // full-width row: x clamps at 255 without wrapping
        run_frame(8'd255, 8'd0, 2, -1, -1);
        // random small frames with random backpressure
        for (int k = 0; k < 4; k++) begin
            run_frame(8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)), 2, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
